// File: rtl/y_adder1_pkg.sv
// Shared constants for the y_adder1 leaf adder cell.
// Holds the default and maximum supported operand width.
package y_adder1_pkg;

  localparam int WIDTH_DEFAULT = 1;
  localparam int WIDTH_MAX     = 64;

endpackage

// File: rtl/y_adder1_if.sv
// Operand/result bundle for y_adder1; zero-latency sum plus a 1-cycle registered copy.
// No backpressure: the registered copy is overwritten whenever in_valid is seen.
interface y_adder1_if
  import y_adder1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic [WIDTH-1:0] z_q;
  logic             cout_q;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  z, cout, z_q, cout_q, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output z, cout, z_q, cout_q, out_valid
  );

endinterface

// File: rtl/y_fa_cell.sv
// One-bit full adder, the link of the ripple-carry chain.
// Purely combinational; no latency, no backpressure.
module y_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/y_adder1.sv
// Ripple-carry adder: combinational z/cout at zero latency, registered z_q/cout_q/out_valid one cycle later.
// No backpressure: the output register loads on every in_valid and holds otherwise.
module y_adder1
  import y_adder1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  y_adder1_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    y_fa_cell u_fa (
      .a   (bus.a[i]),
      .b   (bus.b[i]),
      .cin (carry[i]),
      .s   (sum[i]),
      .co  (carry[i+1])
    );
  end

  assign bus.z    = sum;
  assign bus.cout = carry[WIDTH];

  // Reset wins over in_valid; without in_valid the data registers hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.z_q       <= '0;
      bus.cout_q    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.z_q    <= sum;
        bus.cout_q <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_y_adder1.sv
// Directed and random checks of y_adder1 at WIDTH=1 and WIDTH=4 against an arithmetic model.
module tb_y_adder1;

  logic clk = 1'b0;
  logic reset_n;
  int   ncmp  = 0;
  int   nfail = 0;

  y_adder1_if #(.WIDTH(1)) bus1 ();
  y_adder1_if #(.WIDTH(4)) bus4 ();

  y_adder1 #(.WIDTH(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  y_adder1 #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference state of the registered outputs, per instance.
  logic [0:0] e1_zq;
  logic       e1_cq, e1_ov;
  logic [3:0] e4_zq;
  logic       e4_cq, e4_ov;

  initial begin
    logic [1:0] s1;
    logic [4:0] s4;
    logic       rn;

    reset_n = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.in_valid = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.in_valid = 1'b0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_zq1",  64'(bus1.z_q), 64'd0);
    check("rst_cq1",  64'(bus1.cout_q), 64'd0);
    check("rst_ov1",  64'(bus1.out_valid), 64'd0);
    check("rst_zq4",  64'(bus4.z_q), 64'd0);
    check("rst_cq4",  64'(bus4.cout_q), 64'd0);
    check("rst_ov4",  64'(bus4.out_valid), 64'd0);

    @(negedge clk);
    reset_n = 1'b1;

    // Exhaustive single-bit sweep of the combinational path.
    for (int i = 0; i < 8; i++) begin
      int v;
      v = i;
      @(negedge clk);
      bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0];
      s1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      #1;
      check("sweep_z",    64'(bus1.z),    64'(s1[0]));
      check("sweep_cout", 64'(bus1.cout), 64'(s1[1]));
    end

    // Capture 1+1+1.
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    check("cap_zq", 64'(bus1.z_q),       64'd1);
    check("cap_cq", 64'(bus1.cout_q),    64'd1);
    check("cap_ov", 64'(bus1.out_valid), 64'd1);

    // Hold with in_valid low while inputs change.
    @(negedge clk);
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0; bus1.in_valid = 1'b0;
    #1;
    check("hold_z",    64'(bus1.z),    64'd0);
    check("hold_cout", 64'(bus1.cout), 64'd0);
    @(posedge clk); #1;
    check("hold_zq", 64'(bus1.z_q),       64'd1);
    check("hold_cq", 64'(bus1.cout_q),    64'd1);
    check("hold_ov", 64'(bus1.out_valid), 64'd0);

    // Reset and in_valid on the same edge.
    @(negedge clk);
    reset_n = 1'b0;
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    #1;
    check("prio_z_comb",    64'(bus1.z),    64'd1);
    check("prio_cout_comb", 64'(bus1.cout), 64'd1);
    @(posedge clk); #1;
    check("prio_zq", 64'(bus1.z_q),       64'd0);
    check("prio_cq", 64'(bus1.cout_q),    64'd0);
    check("prio_ov", 64'(bus1.out_valid), 64'd0);

    @(negedge clk);
    reset_n = 1'b1;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0; bus1.in_valid = 1'b0;

    // Four-bit ripple boundaries.
    bus4.a = 4'hF; bus4.b = 4'h0; bus4.cin = 1'b1;
    #1;
    check("rip_f01_z",    64'(bus4.z),    64'h0);
    check("rip_f01_cout", 64'(bus4.cout), 64'd1);
    @(negedge clk);
    bus4.a = 4'h7; bus4.b = 4'h8; bus4.cin = 1'b0;
    #1;
    check("rip_780_z",    64'(bus4.z),    64'hF);
    check("rip_780_cout", 64'(bus4.cout), 64'd0);
    @(negedge clk);
    bus4.a = 4'hF; bus4.b = 4'hF; bus4.cin = 1'b1;
    #1;
    check("rip_ff1_z",    64'(bus4.z),    64'hF);
    check("rip_ff1_cout", 64'(bus4.cout), 64'd1);
    @(negedge clk);
    bus4.a = 4'h0; bus4.b = 4'h0; bus4.cin = 1'b0;
    #1;
    check("rip_000_z",    64'(bus4.z),    64'h0);
    check("rip_000_cout", 64'(bus4.cout), 64'd0);

    // Registers were cleared by the last reset and nothing has been captured since.
    e1_zq = '0; e1_cq = 1'b0; e1_ov = 1'b0;
    e4_zq = '0; e4_cq = 1'b0; e4_ov = 1'b0;

    // Random stream, with occasional mid-stream resets.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      rn = ($urandom_range(0, 39) != 0);
      reset_n = rn;
      bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.cin = 1'($urandom);
      bus4.in_valid = ($urandom_range(0, 3) != 0);
      bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.cin = 1'($urandom);
      bus1.in_valid = ($urandom_range(0, 3) != 0);
      s4 = 5'(bus4.a) + 5'(bus4.b) + 5'(bus4.cin);
      s1 = 2'(bus1.a) + 2'(bus1.b) + 2'(bus1.cin);
      #1;
      check("rnd4_sum", 64'({bus4.cout, bus4.z}), 64'(s4));
      check("rnd1_sum", 64'({bus1.cout, bus1.z}), 64'(s1));

      if (!rn) begin
        e4_zq = '0; e4_cq = 1'b0;
        e1_zq = '0; e1_cq = 1'b0;
      end else begin
        if (bus4.in_valid) begin e4_zq = s4[3:0]; e4_cq = s4[4]; end
        if (bus1.in_valid) begin e1_zq = s1[0];   e1_cq = s1[1]; end
      end
      e4_ov = rn & bus4.in_valid;
      e1_ov = rn & bus1.in_valid;

      @(posedge clk); #1;
      check("rnd4_zq", 64'(bus4.z_q),       64'(e4_zq));
      check("rnd4_cq", 64'(bus4.cout_q),    64'(e4_cq));
      check("rnd4_ov", 64'(bus4.out_valid), 64'(e4_ov));
      check("rnd1_zq", 64'(bus1.z_q),       64'(e1_zq));
      check("rnd1_cq", 64'(bus1.cout_q),    64'(e1_cq));
      check("rnd1_ov", 64'(bus1.out_valid), 64'(e1_ov));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
